// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: ALU operation codes, issue FSM states and comparison decode
package alu_issue_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_LT, ALU_SLTU, ALU_LTU, ALU_GE, ALU_GEU, ALU_EQ, ALU_NE
  } alu_op;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_SETTLE, ST_RESP} issue_state;
  function automatic logic is_cmp_op(alu_op op);
    return op inside {ALU_SLT, ALU_LT, ALU_SLTU, ALU_LTU, ALU_GE, ALU_GEU, ALU_EQ, ALU_NE};
  endfunction
endpackage

// File: rtl/alu_issue.sv
// alu_issue: sequences one ALU operation per handshake and returns the settled result
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  alu_op            req_op_i,
  input  logic [31:0]      req_a_i,
  input  logic [31:0]      req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             alu_req_o,
  output logic             alu_en_o,
  output alu_op            alu_operator_o,
  output logic [31:0]      alu_op_a_o,
  output logic [31:0]      alu_op_b_o,
  input  logic [31:0]      alu_result_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_result_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_is_cmp_o,
  output logic             rsp_cond_o,
  output logic             busy_o
);
  issue_state state;
  logic [3:0] cnt;
  logic [TAG_W-1:0] tag_q;
  logic accept;
  always_comb begin
    req_ready_o = (state == ST_IDLE) | ((state == ST_RESP) & rsp_ready_i);
    accept = req_valid_i & req_ready_o;
    busy_o = state != ST_IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt <= '0;
      tag_q <= '0;
      alu_req_o <= 1'b0;
      alu_en_o <= 1'b0;
      alu_operator_o <= ALU_ADD;
      alu_op_a_o <= '0;
      alu_op_b_o <= '0;
      rsp_valid_o <= 1'b0;
      rsp_result_o <= '0;
      rsp_tag_o <= '0;
      rsp_is_cmp_o <= 1'b0;
      rsp_cond_o <= 1'b0;
    end else begin
      // Operands only change on an accepted handshake, so they hold between operations
      if (accept) begin
        alu_operator_o <= req_op_i;
        alu_op_a_o <= req_a_i;
        alu_op_b_o <= req_b_i;
        tag_q <= req_tag_i;
        alu_req_o <= 1'b1;
      end
      case (state)
        ST_IDLE: if (req_valid_i) state <= ST_SETUP;
        ST_SETUP: begin
          alu_en_o <= 1'b1;
          state <= ST_STROBE;
        end
        ST_STROBE: begin
          alu_en_o <= 1'b0;
          alu_req_o <= 1'b0;
          cnt <= 4'(SETTLE_CYCLES);
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            rsp_result_o <= alu_result_i;
            rsp_tag_o <= tag_q;
            rsp_is_cmp_o <= is_cmp_op(alu_operator_o);
            rsp_cond_o <= is_cmp_op(alu_operator_o) & alu_result_i[0];
            rsp_valid_o <= 1'b1;
            state <= ST_RESP;
          end
        end
        ST_RESP: if (rsp_ready_i) begin
          rsp_valid_o <= 1'b0;
          state <= req_valid_i ? ST_SETUP : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed checks of alu_issue against a behavioural ALU
module tb_alu_issue;
  import alu_issue_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 1'b0, req_valid2 = 1'b0, rsp_ready = 1'b0, rsp_ready2 = 1'b0;
  alu_op req_op = ALU_ADD;
  logic [31:0] req_a = '0, req_b = '0;
  logic [3:0] req_tag = '0;
  logic req_ready, alu_req, alu_en, rsp_valid, rsp_is_cmp, rsp_cond, busy;
  alu_op alu_operator;
  logic [31:0] alu_a, alu_b, alu_result, rsp_result;
  logic [3:0] rsp_tag;
  logic req_ready2, alu_req2, alu_en2, rsp_valid2, rsp_is_cmp2, rsp_cond2, busy2;
  alu_op alu_operator2;
  logic [31:0] alu_a2, alu_b2, alu_result2, rsp_result2;
  logic [3:0] rsp_tag2;
  alu_op cap_op = ALU_ADD, cap_op2 = ALU_ADD;
  logic [31:0] cap_a = '0, cap_b = '0, cap_a2 = '0, cap_b2 = '0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  alu_issue #(.TAG_W(4), .SETTLE_CYCLES(1)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b), .req_tag_i(req_tag),
    .alu_req_o(alu_req), .alu_en_o(alu_en), .alu_operator_o(alu_operator),
    .alu_op_a_o(alu_a), .alu_op_b_o(alu_b), .alu_result_i(alu_result),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .rsp_tag_o(rsp_tag), .rsp_is_cmp_o(rsp_is_cmp), .rsp_cond_o(rsp_cond), .busy_o(busy));

  alu_issue #(.TAG_W(4), .SETTLE_CYCLES(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid2), .req_ready_o(req_ready2),
    .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b), .req_tag_i(req_tag),
    .alu_req_o(alu_req2), .alu_en_o(alu_en2), .alu_operator_o(alu_operator2),
    .alu_op_a_o(alu_a2), .alu_op_b_o(alu_b2), .alu_result_i(alu_result2),
    .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready2), .rsp_result_o(rsp_result2),
    .rsp_tag_o(rsp_tag2), .rsp_is_cmp_o(rsp_is_cmp2), .rsp_cond_o(rsp_cond2), .busy_o(busy2));

  function automatic logic [31:0] alu_f(alu_op op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_XOR: return a ^ b;
      ALU_OR:  return a | b;
      ALU_AND: return a & b;
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      ALU_SRA: return $signed(a) >>> b[4:0];
      ALU_SLT, ALU_LT: return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU, ALU_LTU: return {31'b0, a < b};
      ALU_GE:  return {31'b0, $signed(a) >= $signed(b)};
      ALU_GEU: return {31'b0, a >= b};
      ALU_EQ:  return {31'b0, a == b};
      default: return {31'b0, a != b};
    endcase
  endfunction

  // ALU stand-in: captures its operands on the rising edge of en
  always @(posedge alu_en) begin cap_op = alu_operator; cap_a = alu_a; cap_b = alu_b; end
  always @(posedge alu_en2) begin cap_op2 = alu_operator2; cap_a2 = alu_a2; cap_b2 = alu_b2; end
  assign alu_result = alu_f(cap_op, cap_a, cap_b);
  assign alu_result2 = alu_f(cap_op2, cap_a2, cap_b2);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input alu_op op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input logic [31:0] er, input logic ec,
                        input logic ed, input string nm);
    int lat = 0, en_n = 0, req_n = 0;
    req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1; rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    while (!rsp_valid && lat < 20) begin
      en_n += int'(alu_en); req_n += int'(alu_req);
      step(); lat++;
    end
    tests++; if (lat !== 3) begin fails++; $display("FAIL %s latency got %0d want 3", nm, lat); end
    tests++; if (rsp_result !== er) begin fails++; $display("FAIL %s result got %h want %h", nm, rsp_result, er); end
    tests++; if (rsp_tag !== tag) begin fails++; $display("FAIL %s tag got %h want %h", nm, rsp_tag, tag); end
    tests++; if (rsp_is_cmp !== ec) begin fails++; $display("FAIL %s is_cmp got %b want %b", nm, rsp_is_cmp, ec); end
    tests++; if (rsp_cond !== ed) begin fails++; $display("FAIL %s cond got %b want %b", nm, rsp_cond, ed); end
    tests++; if (en_n !== 1 || req_n !== 2) begin fails++; $display("FAIL %s strobes en=%0d req=%0d want 1/2", nm, en_n, req_n); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL %s retire valid=%b busy=%b want 0/0", nm, rsp_valid, busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    tests++;
    if ({rsp_valid, alu_req, alu_en, busy, rsp_is_cmp, rsp_cond} !== 6'b0 || alu_operator !== ALU_ADD ||
        alu_a !== 0 || alu_b !== 0 || rsp_result !== 0 || rsp_tag !== 0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL reset outputs valid=%b req=%b en=%b busy=%b rdy=%b want 0/0/0/0/1", rsp_valid, alu_req, alu_en, busy, req_ready);
    end
  endtask

  task automatic test_add();
    req_op = ALU_ADD; req_a = 5; req_b = 7; req_tag = 3; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    tests++; if (alu_req !== 1'b1 || alu_en !== 1'b0 || alu_a !== 5 || alu_b !== 7 || busy !== 1'b1) begin
      fails++; $display("FAIL add_setup req=%b en=%b a=%h b=%h want 1/0/5/7", alu_req, alu_en, alu_a, alu_b); end
    step();
    tests++; if (alu_en !== 1'b1 || alu_req !== 1'b1) begin fails++; $display("FAIL add_strobe en=%b req=%b want 1/1", alu_en, alu_req); end
    step();
    tests++; if (alu_en !== 1'b0 || alu_req !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL add_settle en=%b req=%b valid=%b want 0/0/0", alu_en, alu_req, rsp_valid); end
    step();
    tests++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd12 || rsp_tag !== 4'd3 || rsp_is_cmp !== 1'b0 || rsp_cond !== 1'b0) begin
      fails++; $display("FAIL add_resp valid=%b result=%h tag=%h want 1/0000000c/3", rsp_valid, rsp_result, rsp_tag); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_a !== 5) begin fails++; $display("FAIL add_retire valid=%b busy=%b a=%h want 0/0/5", rsp_valid, busy, alu_a); end
  endtask

  task automatic test_arith();
    run_op(ALU_SUB, 32'd0, 32'd1, 4'd1, 32'hFFFFFFFF, 1'b0, 1'b0, "sub");
    run_op(ALU_SLL, 32'd1, 32'd31, 4'd2, 32'h80000000, 1'b0, 1'b0, "sll");
  endtask

  task automatic test_cmp();
    run_op(ALU_GE, 32'hFFFFFFFF, 32'd1, 4'd4, 32'd0, 1'b1, 1'b0, "ge");
    run_op(ALU_GEU, 32'hFFFFFFFF, 32'd1, 4'd5, 32'd1, 1'b1, 1'b1, "geu");
  endtask

  task automatic test_back_to_back();
    req_op = ALU_XOR; req_a = 32'hF0F0; req_b = 32'h0FF0; req_tag = 4'd5; req_valid = 1'b1;
    step();
    req_op = ALU_AND; req_a = 32'hFF; req_b = 32'h0F; req_tag = 4'd6;
    step(); step(); step();
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'hFF00 || rsp_tag !== 4'd5 || req_ready !== 1'b0 || alu_a !== 32'hF0F0) begin
        fails++; $display("FAIL bp_hold%0d valid=%b result=%h tag=%h rdy=%b want 1/0000ff00/5/0", i, rsp_valid, rsp_result, rsp_tag, req_ready);
      end
      step();
    end
    rsp_ready = 1'b1; #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL bp_ready got %b want 1", req_ready); end
    step();
    req_valid = 1'b0;
    tests++; if (rsp_valid !== 1'b0 || alu_req !== 1'b1 || alu_a !== 32'hFF || alu_operator !== ALU_AND) begin
      fails++; $display("FAIL bp_accept valid=%b req=%b a=%h want 0/1/000000ff", rsp_valid, alu_req, alu_a); end
    step(); step(); step();
    tests++; if (rsp_valid !== 1'b1 || rsp_result !== 32'h0F || rsp_tag !== 4'd6) begin
      fails++; $display("FAIL bp_second valid=%b result=%h tag=%h want 1/0000000f/6", rsp_valid, rsp_result, rsp_tag); end
    step(); rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_op = ALU_SUB; req_a = 32'd10; req_b = 32'd3; req_tag = 4'd9; req_valid = 1'b1;
    step(); req_valid = 1'b0; step();
    tests++; if (alu_en !== 1'b1) begin fails++; $display("FAIL rst_strobe en got %b want 1", alu_en); end
    rst = 1'b1; step(); rst = 1'b0;
    tests++;
    if ({rsp_valid, alu_req, alu_en, busy} !== 4'b0 || alu_operator !== ALU_ADD || alu_a !== 0 || alu_b !== 0 || rsp_tag !== 0) begin
      fails++; $display("FAIL rst_mid valid=%b req=%b en=%b busy=%b a=%h want all 0", rsp_valid, alu_req, alu_en, busy, alu_a); end
    run_op(ALU_EQ, 32'd9, 32'd9, 4'd7, 32'd1, 1'b1, 1'b1, "eq_after_rst");
  endtask

  task automatic test_settle3();
    int lat = 0, en_n = 0, req_n = 0;
    req_op = ALU_ADD; req_a = 32'd2; req_b = 32'd3; req_tag = 4'd1; req_valid2 = 1'b1; rsp_ready2 = 1'b1;
    step();
    req_valid2 = 1'b0;
    while (!rsp_valid2 && lat < 20) begin
      en_n += int'(alu_en2); req_n += int'(alu_req2);
      step(); lat++;
    end
    tests++; if (lat !== 5) begin fails++; $display("FAIL s3_latency got %0d want 5", lat); end
    tests++; if (en_n !== 1 || req_n !== 2) begin fails++; $display("FAIL s3_strobes en=%0d req=%0d want 1/2", en_n, req_n); end
    tests++; if (rsp_result2 !== 32'd5 || rsp_tag2 !== 4'd1) begin fails++; $display("FAIL s3_result got %h/%h want 00000005/1", rsp_result2, rsp_tag2); end
    step();
    tests++; if (rsp_valid2 !== 1'b0 || busy2 !== 1'b0) begin fails++; $display("FAIL s3_retire valid=%b busy=%b want 0/0", rsp_valid2, busy2); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_arith();
    test_cmp();
    test_back_to_back();
    test_reset_mid();
    test_settle3();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
